// File: rtl/rv32i_mem_pkg.sv
// Shared types and constants for the RV32I memory stage.
// Control-word bit positions, funct3 encodings and the access FSM states.
package rv32i_mem_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_RESP = 2'd2,
        DONE      = 2'd3
    } mem_state_t;

    localparam int MEM_READ_BIT  = 0;
    localparam int MEM_WRITE_BIT = 1;
    localparam int FUNCT3_LSB    = 2;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;

    // funct3[1:0] is the access size: 0 byte, 1 half, 2 word, 3 never legal
    function automatic logic [1:0] f3_size(input logic [2:0] f3);
        return f3[1:0];
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus: registered request side from the stage, grant and read
// response from memory.
interface mem_access_stage_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/load_store_align.sv
// Combinational byte-lane handling: store replication and byte enables,
// load shift/extend, and misalignment / illegal-funct3 detection.
module load_store_align
    import rv32i_mem_pkg::*;
(
    input  logic                               is_load,
    input  logic                               is_store,
    input  logic [2:0]                         acc_f3,
    input  logic [1:0]                         acc_off,
    input  logic [31:0]                        st_data,
    output logic [NUM_LANES-1:0][LANE_W-1:0]   st_wdata,
    output logic [NUM_LANES-1:0]               st_be,
    output logic                               fault,
    input  logic [2:0]                         ld_f3,
    input  logic [1:0]                         ld_off,
    input  logic [31:0]                        ld_rdata,
    output logic [31:0]                        ld_data
);

    logic [1:0]  size;
    logic [31:0] shifted;

    assign size = f3_size(acc_f3);

    // Byte stores replicate lane 0 everywhere, halfword stores alternate lanes 0/1
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        assign st_wdata[l] = (size == 2'b00) ? st_data[LANE_W-1:0] :
                             (size == 2'b01) ? st_data[(l % 2)*LANE_W +: LANE_W] :
                                               st_data[l*LANE_W +: LANE_W];
    end

    always_comb begin
        case (size)
            2'b00:   st_be = 4'b0001 << acc_off;
            2'b01:   st_be = 4'b0011 << {acc_off[1], 1'b0};
            default: st_be = 4'b1111;
        endcase
    end

    always_comb begin
        fault = 1'b0;
        if (is_store)
            fault = (acc_f3 != F3_B) && (acc_f3 != F3_H) && (acc_f3 != F3_W);
        else if (is_load)
            fault = (acc_f3 == 3'b011) || (acc_f3 == 3'b110) || (acc_f3 == 3'b111);
        if (is_load || is_store) begin
            if (size == 2'b01 && acc_off[0])
                fault = 1'b1;
            if (size == 2'b10 && acc_off != 2'b00)
                fault = 1'b1;
        end
    end

    assign shifted = ld_rdata >> {ld_off, 3'b000};

    always_comb begin
        case (ld_f3)
            F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   ld_data = {24'd0, shifted[7:0]};
            F3_HU:   ld_data = {16'd0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// RV32I memory stage: request/grant/response FSM on the data bus with
// pipeline stall while an access is outstanding.
module mem_access_stage
    import rv32i_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                clock,
    input  logic                sync_reset,
    input  logic [7:0]          control_signals_M,
    input  logic [31:0]         ALU_result_M,
    input  logic [31:0]         write_data_M,
    output logic [31:0]         load_data_M,
    output logic                stall_M,
    output logic                mem_fault_M,
    mem_access_stage_if.master  bus
);

    mem_state_t state, next_state;

    logic       mem_read, mem_write, is_store, is_load, access, fault;
    logic [2:0] funct3;
    logic [2:0] ld_f3_q;
    logic [1:0] ld_off_q;
    logic [NUM_LANES-1:0][LANE_W-1:0] wdata_fmt;
    logic [NUM_LANES-1:0]             be_fmt;
    logic [31:0]                      ld_fmt;
    logic                             unused_ctrl;

    assign mem_read    = control_signals_M[MEM_READ_BIT];
    assign mem_write   = control_signals_M[MEM_WRITE_BIT];
    assign funct3      = control_signals_M[FUNCT3_LSB +: 3];
    assign is_store    = mem_write;
    assign is_load     = mem_read & ~mem_write;
    assign access      = mem_read | mem_write;
    assign unused_ctrl = ^control_signals_M[7:5];

    load_store_align u_align (
        .is_load  (is_load),
        .is_store (is_store),
        .acc_f3   (funct3),
        .acc_off  (ALU_result_M[1:0]),
        .st_data  (write_data_M),
        .st_wdata (wdata_fmt),
        .st_be    (be_fmt),
        .fault    (fault),
        .ld_f3    (ld_f3_q),
        .ld_off   (ld_off_q),
        .ld_rdata (bus.mem_rdata),
        .ld_data  (ld_fmt)
    );

    always_comb begin
        next_state  = state;
        stall_M     = 1'b0;
        mem_fault_M = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    if (fault) begin
                        mem_fault_M = 1'b1;
                    end else begin
                        stall_M    = 1'b1;
                        next_state = REQ;
                    end
                end
            end
            REQ: begin
                stall_M = 1'b1;
                if (bus.mem_gnt)
                    next_state = bus.mem_we ? DONE : WAIT_RESP;
            end
            WAIT_RESP: begin
                stall_M = 1'b1;
                if (bus.mem_rvalid)
                    next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Load offset and funct3 are captured with the request so the response
    // is formatted from the access that was actually issued.
    always_ff @(posedge clock) begin
        if (!sync_reset) begin
            state         <= IDLE;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= '0;
            load_data_M   <= '0;
            ld_f3_q       <= '0;
            ld_off_q      <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (access && !fault) begin
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= is_store;
                        bus.mem_addr  <= ADDR_W'({ALU_result_M[31:2], 2'b00});
                        bus.mem_wdata <= wdata_fmt;
                        bus.mem_be    <= be_fmt;
                        ld_f3_q       <= funct3;
                        ld_off_q      <= ALU_result_M[1:0];
                    end
                end
                REQ: begin
                    if (bus.mem_gnt)
                        bus.mem_req <= 1'b0;
                end
                WAIT_RESP: begin
                    if (bus.mem_rvalid)
                        load_data_M <= ld_fmt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: bench acts as memory, per-cycle
// comparison against an arithmetic model of the access rules.
module tb_mem_access_stage;
    import rv32i_mem_pkg::*;

    logic        clock = 1'b0;
    logic        sync_reset;
    logic [7:0]  ctrl;
    logic [31:0] alu, wd;
    logic [31:0] load_data_M;
    logic        stall_M, mem_fault_M;

    always #5 clock = ~clock;

    mem_access_stage_if #(.ADDR_W(32)) bus ();

    mem_access_stage #(.ADDR_W(32)) dut (
        .clock             (clock),
        .sync_reset        (sync_reset),
        .control_signals_M (ctrl),
        .ALU_result_M      (alu),
        .write_data_M      (wd),
        .load_data_M       (load_data_M),
        .stall_M           (stall_M),
        .mem_fault_M       (mem_fault_M),
        .bus               (bus.master)
    );

    int vectors = 0, miscompares = 0, stall_cnt = 0;

    logic        chk_en = 1'b0, chk_bus = 1'b0, chk_wd = 1'b0;
    logic        e_stall, e_fault, e_req, e_we;
    logic [31:0] e_ld, e_addr, e_wd, model_ld;
    logic [3:0]  e_be;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] mk(input logic rd, input logic wr, input logic [2:0] f3);
        return {3'b000, f3, wr, rd};
    endfunction

    function automatic logic model_fault(input logic rd, input logic wr, input logic [2:0] f3,
                                         input logic [31:0] a);
        if (!(rd || wr)) return 1'b0;
        if (wr && f3 > 3'd2) return 1'b1;
        if (!wr && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
        if ((f3 % 4) == 1 && (a % 2) != 0) return 1'b1;
        if ((f3 % 4) == 2 && (a % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        if ((f3 % 4) == 0) return 4'(1 << (a % 4));
        if ((f3 % 4) == 1) return 4'(3 << (a % 4));
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wd(input logic [2:0] f3, input logic [31:0] d);
        if ((f3 % 4) == 0) return (d & 32'hFF) * 32'h0101_0101;
        if ((f3 % 4) == 1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] r);
        logic [31:0] v;
        v = r >> (8 * (a % 4));
        case (f3)
            3'd0:    return ((v & 32'hFF) ^ 32'h80) - 32'h80;
            3'd1:    return ((v & 32'hFFFF) ^ 32'h8000) - 32'h8000;
            3'd4:    return v & 32'hFF;
            3'd5:    return v & 32'hFFFF;
            default: return v;
        endcase
    endfunction

    always @(negedge clock) begin
        if (chk_en) begin
            if (stall_M) stall_cnt++;
            chk("stall_M", stall_M, e_stall);
            chk("mem_fault_M", mem_fault_M, e_fault);
            chk("mem_req", bus.mem_req, e_req);
            chk("load_data_M", load_data_M, e_ld);
            if (chk_bus) begin
                chk("mem_addr", bus.mem_addr, e_addr);
                chk("mem_we", bus.mem_we, e_we);
                if (chk_wd) begin
                    chk("mem_be", bus.mem_be, e_be);
                    chk("mem_wdata", bus.mem_wdata, e_wd);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // One memory-stage instruction from arrival in IDLE through DONE.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d,
                             input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                             output int stalls);
        logic flt;
        flt = model_fault(rd, wr, f3, a);
        stall_cnt = 0;
        ctrl = mk(rd, wr, f3); alu = a; wd = d;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        e_stall = (rd || wr) && !flt; e_fault = flt; e_req = 1'b0; e_ld = model_ld;
        chk_bus = 1'b0; chk_wd = 1'b0;
        cyc();
        if (flt || !(rd || wr)) begin
            stalls = stall_cnt;
            return;
        end
        e_fault = 1'b0; e_stall = 1'b1; e_req = 1'b1;
        chk_bus = 1'b1; e_addr = a & ~32'h3; e_we = wr; chk_wd = wr;
        e_be = model_be(f3, a); e_wd = model_wd(f3, d);
        for (int i = 0; i <= gnt_dly; i++) begin
            bus.mem_gnt    = (i == gnt_dly);
            bus.mem_rvalid = (i != gnt_dly);
            bus.mem_rdata  = 32'hBAD0_0000 + i;
            cyc();
        end
        chk_bus = 1'b0; e_req = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        if (rd && !wr) begin
            for (int j = 0; j <= rv_dly; j++) begin
                bus.mem_rvalid = (j == rv_dly);
                bus.mem_gnt    = (j != rv_dly);
                bus.mem_rdata  = (j == rv_dly) ? rdata : 32'h5A5A_5A5A;
                cyc();
            end
            model_ld = model_load(f3, a, rdata);
        end
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        e_stall = 1'b0; e_ld = model_ld;
        cyc();
        stalls = stall_cnt;
    endtask

    task automatic do_nop();
        ctrl = 8'hE0; alu = 32'h0000_0123; wd = 32'hFFFF_FFFF;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        e_stall = 1'b0; e_fault = 1'b0; e_req = 1'b0; e_ld = model_ld;
        chk_bus = 1'b0;
        cyc();
    endtask

    int st;

    initial begin
        sync_reset = 1'b0; ctrl = 8'h00; alu = '0; wd = '0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        model_ld = '0;
        repeat (2) cyc();
        chk("rst_req", bus.mem_req, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_be", bus.mem_be, 0);
        chk("rst_ld", load_data_M, 0);
        chk("rst_stall", stall_M, 0);
        sync_reset = 1'b1;
        chk_en = 1'b1;

        do_access(1'b0, 1'b1, F3_W, 32'h100, 32'hDEAD_BEEF, 0, 0, 0, st);
        chk("sw_stall_cycles", st, 2);
        chk("sw_addr", bus.mem_addr, 32'h100);
        chk("sw_be", bus.mem_be, 4'hF);
        chk("sw_we", bus.mem_we, 1);
        chk("sw_wdata", bus.mem_wdata, 32'hDEAD_BEEF);

        do_access(1'b1, 1'b0, F3_B, 32'h103, 0, 2, 0, 32'h80FF_0000, st);
        chk("lb_stall_cycles", st, 5);
        chk("lb_data", load_data_M, 32'hFFFF_FF80);

        do_access(1'b1, 1'b0, F3_HU, 32'h102, 0, 0, 0, 32'h8001_1234, st);
        chk("lhu_data", load_data_M, 32'h0000_8001);

        do_access(1'b0, 1'b1, F3_H, 32'h102, 32'h0000_ABCD, 1, 0, 0, st);
        chk("sh_wdata", bus.mem_wdata, 32'hABCD_ABCD);
        chk("sh_be", bus.mem_be, 4'b1100);
        chk("sh_stall_cycles", st, 3);

        do_access(1'b1, 1'b0, F3_W, 32'h101, 0, 0, 0, 0, st);
        chk("lw_mis_stall_cycles", st, 0);
        chk("lw_mis_req", bus.mem_req, 0);
        chk("lw_mis_ld", load_data_M, 32'h0000_8001);

        // More formatting and fault corners
        do_access(1'b1, 1'b0, F3_H, 32'h202, 0, 0, 2, 32'h9ABC_0000, st);
        chk("lh_data", load_data_M, 32'hFFFF_9ABC);
        chk("lh_stall_cycles", st, 5);
        do_access(1'b1, 1'b0, F3_BU, 32'h301, 0, 0, 0, 32'h0000_F700, st);
        chk("lbu_data", load_data_M, 32'h0000_00F7);
        do_access(1'b0, 1'b1, F3_B, 32'h401, 32'h1234_56A5, 0, 0, 0, st);
        chk("sb_be", bus.mem_be, 4'b0010);
        chk("sb_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
        do_access(1'b1, 1'b1, F3_H, 32'h500, 32'h0000_7777, 0, 0, 0, st);
        chk("rw_is_store_we", bus.mem_we, 1);
        chk("rw_stall_cycles", st, 2);
        do_access(1'b0, 1'b1, 3'b011, 32'h600, 0, 0, 0, 0, st);
        do_access(1'b0, 1'b1, F3_W, 32'h602, 0, 0, 0, 0, st);
        do_access(1'b1, 1'b0, 3'b110, 32'h600, 0, 0, 0, 0, st);
        do_access(1'b1, 1'b0, F3_H, 32'h603, 0, 0, 0, 0, st);
        do_access(1'b0, 1'b1, F3_BU, 32'h600, 0, 0, 0, 0, st);

        // Back-to-back: SB, ADD, LW
        do_access(1'b0, 1'b1, F3_B, 32'h700, 32'h0000_0011, 0, 0, 0, st);
        do_nop();
        do_access(1'b1, 1'b0, F3_W, 32'h704, 0, 0, 0, 32'hCAFE_F00D, st);
        chk("b2b_lw_data", load_data_M, 32'hCAFE_F00D);
        chk("b2b_lw_stall_cycles", st, 3);

        // Reset while waiting for a response; the late rvalid must be ignored
        ctrl = mk(1'b1, 1'b0, F3_W); alu = 32'h800;
        e_stall = 1'b1; e_fault = 1'b0; e_req = 1'b0; e_ld = model_ld; chk_bus = 1'b0;
        cyc();
        bus.mem_gnt = 1'b1; e_req = 1'b1;
        cyc();
        bus.mem_gnt = 1'b0; e_req = 1'b0;
        cyc();
        sync_reset = 1'b0; ctrl = 8'h00;
        cyc();
        sync_reset = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_5678;
        model_ld = '0; e_ld = '0; e_stall = 1'b0;
        cyc();
        bus.mem_rvalid = 1'b0;
        chk("rst_mid_ld", load_data_M, 0);
        chk("rst_mid_req", bus.mem_req, 0);
        chk("rst_mid_addr", bus.mem_addr, 0);
        chk("rst_mid_wdata", bus.mem_wdata, 0);
        chk("rst_mid_we", bus.mem_we, 0);
        chk("rst_mid_be", bus.mem_be, 0);
        do_nop();
        chk("rst_mid_stall", stall_M, 0);
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
